// File: rtl/chunked_borrow_select_subtractor_pkg.sv
// Shared definitions for the chunked borrow-select subtractor: default
// geometry and the sequencing FSM state type.
package chunked_borrow_select_subtractor_pkg;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_CHUNKS      = 4;
  localparam int DEF_TOTAL_WIDTH = DEF_WIDTH * DEF_CHUNKS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chunked_borrow_select_subtractor_ripple_subtractor.sv
// Gate-level WIDTH-bit ripple subtractor: diff = a - b - bin, with the
// borrow rippling from bit 0 upward. The chunked subtractor runs two of
// these side by side, one per possible borrow-in.
module ripple_subtractor
  import chunked_borrow_select_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  logic [WIDTH:0] brw;

  assign brw[0] = bin;

  // Full-subtractor cell per bit: borrow out when a<b, or a==b with borrow in
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign diff[i]    = a[i] ^ b[i] ^ brw[i];
    assign brw[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
  end

  assign bout = brw[WIDTH];

endmodule

// File: rtl/chunked_borrow_select_subtractor.sv
// Multi-cycle wide subtractor: diff = a - b over WIDTH*CHUNKS bits, one
// chunk per clock, LSB chunk first. Each chunk is evaluated for both
// borrow-in values and the registered borrow of the previous chunk picks
// the result. Valid/ready handshake on both the operand and result side.
// Optional feature macro: SUB_FLAGS_EN adds zero and signed-overflow flags.
module chunked_borrow_select_subtractor
  import chunked_borrow_select_subtractor_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CHUNKS = DEF_CHUNKS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH*CHUNKS-1:0]  a,
  input  logic [WIDTH*CHUNKS-1:0]  b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH*CHUNKS-1:0]  diff,
  output logic                     bout
`ifdef SUB_FLAGS_EN
  ,
  output logic                     zero,
  output logic                     ovf
`endif
);

  localparam int TOTAL = WIDTH * CHUNKS;
  localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  state_t             state;
  logic [TOTAL-1:0]   a_reg;
  logic [TOTAL-1:0]   b_reg;
  logic [IDX_W-1:0]   idx;
  logic               borrow;

  logic [WIDTH-1:0]   a_chunk;
  logic [WIDTH-1:0]   b_chunk;
  logic [WIDTH-1:0]   d0;
  logic [WIDTH-1:0]   d1;
  logic               bo0;
  logic               bo1;
  logic [WIDTH-1:0]   sel_diff;
  logic               sel_bout;
  logic [TOTAL-1:0]   diff_next;

  // Slice out the current chunk and merge the selected result into diff
  always_comb begin
    a_chunk   = a_reg[idx*WIDTH +: WIDTH];
    b_chunk   = b_reg[idx*WIDTH +: WIDTH];
    sel_diff  = borrow ? d1 : d0;
    sel_bout  = borrow ? bo1 : bo0;
    diff_next = diff;
    diff_next[idx*WIDTH +: WIDTH] = sel_diff;
  end

  ripple_subtractor #(.WIDTH(WIDTH)) u_sub_b0 (
    .a    (a_chunk),
    .b    (b_chunk),
    .bin  (1'b0),
    .diff (d0),
    .bout (bo0)
  );

  ripple_subtractor #(.WIDTH(WIDTH)) u_sub_b1 (
    .a    (a_chunk),
    .b    (b_chunk),
    .bin  (1'b1),
    .diff (d1),
    .bout (bo1)
  );

  // Sequencer: accept operands, walk the chunks LSB first, hold the result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      idx       <= '0;
      borrow    <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a;
            b_reg    <= b;
            diff     <= '0;
            bout     <= 1'b0;
            borrow   <= 1'b0;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          diff   <= diff_next;
          borrow <= sel_bout;
          if (idx == LAST_IDX) begin
            bout      <= sel_bout;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SUB_FLAGS_EN
  // Result flags settle together with the last chunk of diff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == IDLE && in_valid && in_ready) begin
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == RUN && idx == LAST_IDX) begin
      zero <= (diff_next == '0);
      ovf  <= (a_reg[TOTAL-1] != b_reg[TOTAL-1]) &&
              (diff_next[TOTAL-1] != a_reg[TOTAL-1]);
    end
  end
`endif

endmodule

// File: tb/tb_chunked_borrow_select_subtractor.sv
// Directed self-checking bench for chunked_borrow_select_subtractor
// (WIDTH=4, CHUNKS=4). Flag checks are compiled in with SUB_FLAGS_EN.
module tb_chunked_borrow_select_subtractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
`ifdef SUB_FLAGS_EN
  logic        zero;
  logic        ovf;
`endif

  int checks;
  int failures;

  chunked_borrow_select_subtractor #(
    .WIDTH  (4),
    .CHUNKS (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SUB_FLAGS_EN
    ,
    .zero      (zero),
    .ovf       (ovf)
`endif
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand pair for a single accept edge; call at a negedge
  task automatic start_op(input logic [15:0] op_a, input logic [15:0] op_b);
    in_valid = 1'b1;
    a        = op_a;
    b        = op_b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid is seen; lat = -1 when the budget runs out
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  // Take the current result with a one-cycle out_ready pulse
  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 16'h0000 || bout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_values: in_ready=%b out_valid=%b diff=%h bout=%b, want 1 0 0000 0",
               in_ready, out_valid, diff, bout);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    int lat;
    start_op(16'h1234, 16'h0234);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_busy: in_ready=%b, want 0", in_ready);
    end
    wait_done(lat);
    checks++;
    if (lat != 4) begin
      failures++;
      $display("[TB] FAIL basic_latency: got %0d edges, want 4", lat);
    end
    checks++;
    if (diff !== 16'h1000 || bout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_result: diff=%h bout=%b, want 1000 0", diff, bout);
    end
    release_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_underflow();
    int lat;
    start_op(16'h0000, 16'h0001);
    wait_done(lat);
    checks++;
    if (lat != 4) begin
      failures++;
      $display("[TB] FAIL underflow_latency: got %0d edges, want 4", lat);
    end
    checks++;
    if (diff !== 16'hFFFF || bout !== 1'b1) begin
      failures++;
      $display("[TB] FAIL underflow_result: diff=%h bout=%b, want ffff 1", diff, bout);
    end
    release_result();
  endtask

  task automatic test_back_pressure();
    int   lat;
    logic stable;
    start_op(16'hABCD, 16'h1111);
    wait_done(lat);
    checks++;
    if (lat != 4) begin
      failures++;
      $display("[TB] FAIL bp_latency: got %0d edges, want 4", lat);
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (diff !== 16'h9ABC || bout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0)
        stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_hold: diff=%h bout=%b out_valid=%b in_ready=%b, want 9abc 0 1 0 for 10 cycles",
               diff, bout, out_valid, in_ready);
    end
    release_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    start_op(16'hABCD, 16'h1111);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || diff !== 16'h0000 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_run_reset: out_valid=%b diff=%h in_ready=%b, want 0 0000 1",
               out_valid, diff, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(16'h0005, 16'h0003);
    wait_done(lat);
    checks++;
    if (lat != 4 || diff !== 16'h0002 || bout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL after_reset_op: lat=%0d diff=%h bout=%b, want 4 0002 0", lat, diff, bout);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 16'hFFFF;
    b         = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    a = 16'h8000;
    b = 16'h0001;
    wait_done(lat);
    checks++;
    if (lat != 4 || diff !== 16'h0000 || bout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_first: lat=%0d diff=%h bout=%b, want 4 0000 0", lat, diff, bout);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_idle_gap: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_second_accept: in_ready=%b, want 0", in_ready);
    end
    wait_done(lat);
    checks++;
    if (lat != 4 || diff !== 16'h7FFF || bout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_second: lat=%0d diff=%h bout=%b, want 4 7fff 0", lat, diff, bout);
    end
`ifdef SUB_FLAGS_EN
    checks++;
    if (ovf !== 1'b1 || zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flags_ovf: ovf=%b zero=%b, want 1 0", ovf, zero);
    end
`endif
    release_result();
  endtask

`ifdef SUB_FLAGS_EN
  task automatic test_flags();
    int lat;
    start_op(16'h8000, 16'h0001);
    wait_done(lat);
    checks++;
    if (lat != 4 || diff !== 16'h7FFF || ovf !== 1'b1 || zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flags_8000: diff=%h ovf=%b zero=%b, want 7fff 1 0", diff, ovf, zero);
    end
    release_result();
    start_op(16'h5555, 16'h5555);
    wait_done(lat);
    checks++;
    if (lat != 4 || diff !== 16'h0000 || zero !== 1'b1 || ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flags_5555: diff=%h zero=%b ovf=%b, want 0000 1 0", diff, zero, ovf);
    end
    release_result();
  endtask
`endif

  // Scenario sequence and summary
  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    test_reset();
    test_basic();
    test_underflow();
    test_back_pressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SUB_FLAGS_EN
    test_flags();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
